// File: rtl/mux_tree_cfg_loader.sv
// Frame loader for a bank of mux_tree_tapbuf routing muxes: collects one select index per mux
// into shadow registers and commits the whole frame to sram/sram_inv in a single cycle.
module mux_tree_cfg_loader #(
   parameter int unsigned NUM_MUX  = 8,
   parameter int unsigned MUX_SIZE = 15,
   parameter int unsigned SEL_BITS = 4
) (
   input  logic                         prog_clk,
   input  logic                         pReset,
   input  logic                         cfg_valid,
   output logic                         cfg_ready,
   input  logic [SEL_BITS-1:0]          cfg_sel,
   input  logic                         cfg_abort,
   output logic                         busy,
   output logic                         done,
   output logic                         err,
   output logic [$clog2(NUM_MUX)-1:0]   err_mux,
   output logic [NUM_MUX*SEL_BITS-1:0]  sram,
   output logic [NUM_MUX*SEL_BITS-1:0]  sram_inv
);

   localparam int unsigned CNT_W = $clog2(NUM_MUX);

   typedef enum logic [1:0] {IDLE, LOAD, COMMIT, ERR} state_t;

   state_t              state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic [SEL_BITS-1:0] shadow [NUM_MUX];
   logic                xfer, legal;
   logic                wr_shadow, clr_shadow, set_err, clr_err, do_commit;

   assign xfer  = cfg_valid && cfg_ready;
   assign legal = cfg_sel < SEL_BITS'(MUX_SIZE);

   always_ff @(posedge prog_clk) begin
      if (pReset) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      wr_shadow  = 1'b0;
      clr_shadow = 1'b0;
      set_err    = 1'b0;
      clr_err    = 1'b0;
      do_commit  = 1'b0;
      case (state)
         IDLE, LOAD: begin
            // abort outranks a simultaneous entry, which is handshaken but dropped
            if (cfg_abort) begin
               state_n    = IDLE;
               cnt_n      = '0;
               clr_shadow = 1'b1;
            end else if (xfer) begin
               if (!legal) begin
                  state_n    = ERR;
                  cnt_n      = '0;
                  set_err    = 1'b1;
                  clr_shadow = 1'b1;
               end else begin
                  wr_shadow = 1'b1;
                  if (cnt == CNT_W'(NUM_MUX - 1)) begin
                     state_n = COMMIT;
                     cnt_n   = '0;
                  end else begin
                     state_n = LOAD;
                     cnt_n   = cnt + CNT_W'(1);
                  end
               end
            end
         end
         COMMIT: begin
            do_commit = 1'b1;
            state_n   = IDLE;
            cnt_n     = '0;
         end
         ERR: begin
            if (cfg_abort) begin
               state_n = IDLE;
               cnt_n   = '0;
               clr_err = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         cnt       <= '0;
         cfg_ready <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         err_mux   <= '0;
         sram      <= '0;
         sram_inv  <= '1;
         for (int unsigned m = 0; m < NUM_MUX; m++) shadow[m] <= '0;
      end else begin
         cnt       <= cnt_n;
         cfg_ready <= (state_n == IDLE) || (state_n == LOAD);
         busy      <= (state_n == LOAD) || (state_n == COMMIT);
         done      <= do_commit;
         if (set_err) begin
            err     <= 1'b1;
            err_mux <= cnt;
         end else if (clr_err) begin
            err     <= 1'b0;
         end
         for (int unsigned m = 0; m < NUM_MUX; m++) begin
            if (clr_shadow)
               shadow[m] <= '0;
            else if (wr_shadow && (cnt == CNT_W'(m)))
               shadow[m] <= cfg_sel;
            // sram_inv has its own flop so both buses leave registers directly
            if (do_commit) begin
               sram[m*SEL_BITS +: SEL_BITS]     <= ~shadow[m];
               sram_inv[m*SEL_BITS +: SEL_BITS] <= shadow[m];
            end
         end
      end
   end

endmodule

// File: tb/tb_mux_tree_cfg_loader.sv
// Directed bench for mux_tree_cfg_loader: frame commit, abort, illegal index, stall in COMMIT, reset mid-frame.
module tb_mux_tree_cfg_loader;

   logic        prog_clk = 1'b0;
   logic        pReset, cfg_valid, cfg_abort;
   logic        cfg_ready, busy, done, err;
   logic [3:0]  cfg_sel;
   logic [2:0]  err_mux;
   logic [31:0] sram, sram_inv;

   int n_checks = 0;
   int n_fail   = 0;

   mux_tree_cfg_loader #(.NUM_MUX(8), .MUX_SIZE(15), .SEL_BITS(4)) dut (
      .prog_clk (prog_clk),
      .pReset   (pReset),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_sel  (cfg_sel),
      .cfg_abort(cfg_abort),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_mux  (err_mux),
      .sram     (sram),
      .sram_inv (sram_inv)
   );

   always #5 prog_clk = ~prog_clk;

   task automatic tick;
      @(posedge prog_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [3:0] s);
      cfg_valid = 1'b1;
      cfg_sel   = s;
      tick();
      cfg_valid = 1'b0;
   endtask

   initial begin
      pReset = 1'b1; cfg_valid = 1'b0; cfg_abort = 1'b0; cfg_sel = '0;
      tick(); tick();
      pReset = 1'b0;
      tick();

      // 1: reset state
      chk("rst_sram", sram, 32'h0000_0000);
      chk("rst_sram_inv", sram_inv, 32'hFFFF_FFFF);
      chk("rst_ready", cfg_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_err", err, 1'b0);
      chk("rst_err_mux", err_mux, 3'd0);

      // 2: stream 0..7 back-to-back
      for (int i = 0; i < 7; i++) begin
         push(4'(i));
         chk("f1_sram_hold", sram, 32'h0000_0000);
         chk("f1_busy", busy, 1'b1);
         chk("f1_done_lo", done, 1'b0);
      end
      push(4'd7);
      chk("f1_commit_ready", cfg_ready, 1'b0);
      chk("f1_commit_busy", busy, 1'b1);
      chk("f1_commit_sram_hold", sram, 32'h0000_0000);
      chk("f1_commit_done_lo", done, 1'b0);
      tick();
      chk("f1_done", done, 1'b1);
      chk("f1_sram", sram, 32'h89AB_CDEF);
      chk("f1_sram_inv", sram_inv, 32'h7654_3210);
      chk("f1_busy_lo", busy, 1'b0);
      chk("f1_ready", cfg_ready, 1'b1);
      tick();
      chk("f1_done_pulse", done, 1'b0);

      // 3: abort after 5 entries, then a full frame
      for (int i = 0; i < 5; i++) push(4'd3);
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      chk("ab_busy", busy, 1'b0);
      chk("ab_ready", cfg_ready, 1'b1);
      chk("ab_sram", sram, 32'h89AB_CDEF);
      chk("ab_done", done, 1'b0);
      for (int i = 0; i < 8; i++) push(4'(14 - i));
      chk("f2_ready_commit", cfg_ready, 1'b0);
      tick();
      chk("f2_done", done, 1'b1);
      chk("f2_sram", sram, 32'h8765_4321);
      chk("f2_sram_inv", sram_inv, 32'h789A_BCDE);

      // 4: illegal index 15 at entry 3
      push(4'd0); push(4'd1); push(4'd2); push(4'd15);
      chk("e3_err", err, 1'b1);
      chk("e3_err_mux", err_mux, 3'd3);
      chk("e3_ready", cfg_ready, 1'b0);
      chk("e3_busy", busy, 1'b0);
      chk("e3_sram", sram, 32'h8765_4321);
      cfg_valid = 1'b1; cfg_sel = 4'd5;
      tick();
      cfg_valid = 1'b0;
      chk("e3_err_hold", err, 1'b1);
      chk("e3_ready_hold", cfg_ready, 1'b0);
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      chk("e3_err_clr", err, 1'b0);
      chk("e3_ready_back", cfg_ready, 1'b1);

      // 5: entry stalled in COMMIT, then abort+valid drops the entry
      for (int i = 0; i < 8; i++) push(4'(i + 1));
      cfg_valid = 1'b1; cfg_sel = 4'd9;
      chk("st_ready_commit", cfg_ready, 1'b0);
      tick();
      chk("st_done", done, 1'b1);
      chk("st_sram", sram, 32'h789A_BCDE);
      chk("st_sram_inv", sram_inv, 32'h8765_4321);
      chk("st_busy_lo", busy, 1'b0);
      chk("st_ready", cfg_ready, 1'b1);
      tick();
      chk("st_accept_busy", busy, 1'b1);
      chk("st_accept_done", done, 1'b0);
      cfg_sel = 4'd4; cfg_abort = 1'b1;
      tick();
      cfg_valid = 1'b0; cfg_abort = 1'b0;
      chk("av_busy", busy, 1'b0);
      chk("av_ready", cfg_ready, 1'b1);
      for (int i = 0; i < 7; i++) push((i % 2 == 0) ? 4'd14 : 4'd0);
      chk("av_7_busy", busy, 1'b1);
      chk("av_7_ready", cfg_ready, 1'b1);
      chk("av_7_sram", sram, 32'h789A_BCDE);
      push(4'd0);
      tick();
      chk("av_done", done, 1'b1);
      chk("av_sram", sram, 32'hF1F1_F1F1);
      chk("av_sram_inv", sram_inv, 32'h0E0E_0E0E);

      // 6: reset at entry 6 of a frame after a committed frame
      for (int i = 0; i < 6; i++) push(4'd2);
      cfg_valid = 1'b1; cfg_sel = 4'd2; pReset = 1'b1;
      tick();
      cfg_valid = 1'b0; pReset = 1'b0;
      chk("mr_sram", sram, 32'h0000_0000);
      chk("mr_sram_inv", sram_inv, 32'hFFFF_FFFF);
      chk("mr_ready", cfg_ready, 1'b1);
      chk("mr_busy", busy, 1'b0);
      chk("mr_done", done, 1'b0);
      tick();
      chk("mr_no_done", done, 1'b0);
      for (int i = 0; i < 7; i++) push(4'd3);
      chk("mr_7_ready", cfg_ready, 1'b1);
      chk("mr_7_done", done, 1'b0);
      push(4'd3);
      tick();
      chk("mr_f_done", done, 1'b1);
      chk("mr_f_sram", sram, 32'hCCCC_CCCC);
      chk("mr_f_sram_inv", sram_inv, 32'h3333_3333);

      // error-position boundaries: first and last entry of a frame
      push(4'd15);
      chk("e0_err", err, 1'b1);
      chk("e0_err_mux", err_mux, 3'd0);
      cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
      for (int i = 0; i < 7; i++) push(4'd14);
      push(4'd15);
      chk("e7_err", err, 1'b1);
      chk("e7_err_mux", err_mux, 3'd7);
      tick();
      chk("e7_no_done", done, 1'b0);
      chk("e7_sram", sram, 32'hCCCC_CCCC);
      cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
      chk("e7_clr", err, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
